shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal register, the successor to the single-bit D flip-flop. It holds a WIDTH-bit word and, each enabled clock edge, does one of eight operations: hold, logical shift left/right, arithmetic shift right, rotate left/right, parallel load or clear. Serial ports at both ends allow chaining and serial/parallel conversion. It is the general-purpose storage and serialisation element for datapath and test logic.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- RESET_VAL, 0 (WIDTH bits), value loaded by `reset`
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; loads RESET_VAL into the register
- en  input  1  operation enable; when low the register holds
- mode  input  3  operation select; takes effect only when en=1
- d  input  WIDTH  parallel load data
- ser_in_lsb  input  1  bit shifted into bit 0 on SHL
- ser_in_msb  input  1  bit shifted into bit WIDTH-1 on SHR
- q  output  WIDTH  register contents
- ser_out_msb  output  1  q[WIDTH-1], combinational from q
- ser_out_lsb  output  1  q[0], combinational from q

## Operation
- Priority on each rising clk: reset, then en=0 (hold), then mode.
- Mode encodings:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], ser_in_lsb}.
  - 010 SHR: q <= {ser_in_msb, q[WIDTH-1:1]}.
  - 011 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; ser_in_msb ignored.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 LOAD: q <= d.
  - 111 CLEAR: q <= 0. This is all zeros, not RESET_VAL.
- No state beyond q. The operation is fully determined by the current inputs and q.
- Serial inputs are sampled only in the mode that uses them. In all other modes they are don't-care.
- An X or Z on `mode` while en=1 is a verification error. The bench asserts that `mode` is known whenever en=1.

## Timing
- Reset value: q = RESET_VAL, so ser_out_msb = RESET_VAL[WIDTH-1] and ser_out_lsb = RESET_VAL[0]. These apply from the first clk edge with reset=1.
- Reset dominates en and mode on the same edge.
- Reset asserted mid-stream: the shift is abandoned at that edge and no partial result is kept. Operation resumes on the first edge with reset=0.
- Latency: one cycle. The result of an operation sampled at edge N is visible on q after edge N.
- Serial outputs change in the same cycle as q and have no extra register stage.
- Chaining: connect ser_out_msb of stage k to ser_in_lsb of stage k+1. One bit moves per enabled SHL edge, with no bubble.
- en=0 for any number of cycles: q is stable and there is no drift.
- Back-to-back modes are legal in any order on consecutive edges, with no turnaround cycle.

## Structure
- Shared package `shift_reg_pkg`:
  - localparams MODE_HOLD through MODE_CLEAR (3-bit)
  - mode width constant MODE_W = 3
- The package is imported by both RTL and bench.
- Sub-module `shift_reg_cell`:
  - one bit: sync-reset D flip-flop with enable and a 4-input next-value mux (hold, left neighbour, right neighbour, d)
  - instantiated WIDTH times with a generate loop
  - reset value passed per bit from RESET_VAL
- Top-level logic computes, per bit:
  - neighbour selects from mode
  - end-bit substitutions: ser_in_lsb or q[WIDTH-1] at bit 0; ser_in_msb, q[WIDTH-1] or q[0] at the top bit
  - zero forcing for CLEAR
- Elaboration check: WIDTH < 2 is a fatal error.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, reset=1 for 2 cycles with en=1, mode=LOAD, d=8'hFF -> q=8'hA5, ser_out_msb=1, ser_out_lsb=1.
- Load/shift: LOAD 8'h81, then SHL ×3 with ser_in_lsb=1,0,1 -> q=8'h0D after the third edge. Then SHR ×1 with ser_in_msb=1 -> q=8'h86.
- Rotate/arithmetic: LOAD 8'h80; ROL -> 8'h01; ROR -> 8'h80; ASR ×2 -> 8'hE0; ROR ×8 from 8'h3C -> 8'h3C.
- Enable/hold: LOAD 8'h5A, then en=0 with mode cycling through all 8 codes for 8 cycles -> q stays 8'h5A. Then en=1, mode=HOLD -> still 8'h5A. CLEAR -> 8'h00.
- Reset mid-stream: shifting SHL with ser_in_lsb=1 from 8'h00 for 3 cycles, then reset=1 together with en=1, mode=SHL -> q=RESET_VAL on that edge, with no shifted bit retained.
- Chained serial-to-parallel: two instances, ser_out_msb of the first driving ser_in_lsb of the second. 16 SHL cycles serialising 16'hBEEF MSB-first -> {q2,q1}=16'hBEEF.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the per-bit next-value select used between the top level and its bit cells.
package shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ASR   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'd5;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'd7;

  // SEL_LO takes the value of the next lower bit, SEL_HI the next higher bit.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2,
    SEL_LOAD = 2'd3
  } sel_e;

endpackage

// File: rtl/shift_reg_cell.sv
// One register bit: synchronous-reset flop with enable and a four-way
// next-value mux (hold, lower neighbour, higher neighbour, load bit).
module shift_reg_cell
  import shift_reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  sel_e sel_i,
  input  logic lo_nb_i,
  input  logic hi_nb_i,
  input  logic load_bit_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case (sel_i)
      SEL_HOLD: q_d = q_q;
      SEL_LO:   q_d = lo_nb_i;
      SEL_HI:   q_d = hi_nb_i;
      SEL_LOAD: q_d = load_bit_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RST_BIT;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, shifts, rotates, load and clear, with
// serial ports at both ends for chaining and serial/parallel conversion.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_in_lsb,
  input  logic              ser_in_msb,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out_msb,
  output logic              ser_out_lsb
);

  if (WIDTH < 2) begin : g_width_check
    $fatal(1, "shift_reg_univ: WIDTH must be at least 2");
  end

  sel_e             sel;
  logic             lo_in;
  logic             hi_in;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lo_nb;
  logic [WIDTH-1:0] hi_nb;
  logic [WIDTH-1:0] q_q;

  // End-bit substitutions: lo_in feeds bit 0, hi_in feeds the top bit.
  always_comb begin
    sel      = SEL_HOLD;
    lo_in    = ser_in_lsb;
    hi_in    = ser_in_msb;
    load_val = d;
    case (mode)
      MODE_SHL: sel = SEL_LO;
      MODE_SHR: sel = SEL_HI;
      MODE_ASR: begin
        sel   = SEL_HI;
        hi_in = q_q[WIDTH-1];
      end
      MODE_ROL: begin
        sel   = SEL_LO;
        lo_in = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        sel   = SEL_HI;
        hi_in = q_q[0];
      end
      MODE_LOAD: sel = SEL_LOAD;
      MODE_CLEAR: begin
        sel      = SEL_LOAD;
        load_val = '0;
      end
      default: sel = SEL_HOLD;
    endcase
  end

  assign lo_nb = {q_q[WIDTH-2:0], lo_in};
  assign hi_nb = {hi_in, q_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_cell #(
      .RST_BIT(RESET_VAL[i])
    ) u_cell (
      .clk_i     (clk),
      .reset_i   (reset),
      .en_i      (en),
      .sel_i     (sel),
      .lo_nb_i   (lo_nb[i]),
      .hi_nb_i   (hi_nb[i]),
      .load_bit_i(load_val[i]),
      .q_o       (q_q[i])
    );
  end

  assign q           = q_q;
  assign ser_out_msb = q_q[WIDTH-1];
  assign ser_out_lsb = q_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: an 8-bit main instance checked against a
// reference model through an expected queue, plus a two-stage chain.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, en, ser_in_lsb, ser_in_msb;
  logic [MODE_W-1:0] mode;
  logic [W-1:0]      d, q;
  logic              ser_out_msb, ser_out_lsb;

  logic              c_reset, c_en, c_sin;
  logic [MODE_W-1:0] c_mode;
  logic [W-1:0]      c_d, q1, q2;
  logic              c1_msb, c1_lsb, c2_msb, c2_lsb;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb),
    .q(q), .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb)
  );

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'h00)) u_c1 (
    .clk(clk), .reset(c_reset), .en(c_en), .mode(c_mode), .d(c_d),
    .ser_in_lsb(c_sin), .ser_in_msb(1'b0),
    .q(q1), .ser_out_msb(c1_msb), .ser_out_lsb(c1_lsb)
  );

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'h00)) u_c2 (
    .clk(clk), .reset(c_reset), .en(c_en), .mode(c_mode), .d(c_d),
    .ser_in_lsb(c1_msb), .ser_in_msb(1'b0),
    .q(q2), .ser_out_msb(c2_msb), .ser_out_lsb(c2_lsb)
  );

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur,
                                            input logic [MODE_W-1:0] m,
                                            input logic [W-1:0] dd,
                                            input logic sl, input logic sm);
    case (m)
      MODE_SHL:   return {cur[W-2:0], sl};
      MODE_SHR:   return {sm, cur[W-1:1]};
      MODE_ASR:   return {cur[W-1], cur[W-1:1]};
      MODE_ROL:   return {cur[W-2:0], cur[W-1]};
      MODE_ROR:   return {cur[0], cur[W-1:1]};
      MODE_LOAD:  return dd;
      MODE_CLEAR: return '0;
      default:    return cur;
    endcase
  endfunction

  // driver: drive one edge, push the model's expectation, compare after the edge
  task automatic apply(input logic r, input logic e, input logic [MODE_W-1:0] m,
                       input logic [W-1:0] dd, input logic sl, input logic sm,
                       input string tag);
    logic [W-1:0] exp_v;
    reset = r; en = e; mode = m; d = dd; ser_in_lsb = sl; ser_in_msb = sm;
    if (r) model_q = RV;
    else if (e) model_q = ref_next(model_q, m, dd, sl, sm);
    exp_q.push_back(model_q);
    @(posedge clk);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    assert (q === exp_v) else begin
      errors++;
      $error("FAIL %s q got %h exp %h", tag, q, exp_v);
    end
    checks++;
    assert ({ser_out_msb, ser_out_lsb} === {exp_v[W-1], exp_v[0]}) else begin
      errors++;
      $error("FAIL %s ser_out got %b%b exp %b%b", tag, ser_out_msb, ser_out_lsb,
             exp_v[W-1], exp_v[0]);
    end
  endtask

  task automatic check_const(input string tag, input logic [W-1:0] want);
    checks++;
    assert (q === want) else begin
      errors++;
      $error("FAIL %s q got %h exp %h", tag, q, want);
    end
  endtask

  always @(negedge clk) begin
    if (en === 1'b1) begin
      checks++;
      assert (!$isunknown(mode)) else begin
        errors++;
        $error("FAIL mode_known mode got %b exp known", mode);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] word;
    reset = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
    ser_in_lsb = 1'b0; ser_in_msb = 1'b0;
    c_reset = 1'b1; c_en = 1'b0; c_mode = MODE_HOLD; c_d = '0; c_sin = 1'b0;
    model_q = 'x;

    // reset dominates en/mode
    apply(1, 1, MODE_LOAD, 8'hFF, 0, 0, "reset0");
    apply(1, 1, MODE_LOAD, 8'hFF, 0, 0, "reset1");
    check_const("reset_val", 8'hA5);

    // load and shift
    apply(0, 1, MODE_LOAD, 8'h81, 0, 0, "load81");
    apply(0, 1, MODE_SHL, 8'h00, 1, 0, "shl_a");
    apply(0, 1, MODE_SHL, 8'h00, 0, 1, "shl_b");
    apply(0, 1, MODE_SHL, 8'h00, 1, 0, "shl_c");
    check_const("shl_0d", 8'h0D);
    apply(0, 1, MODE_SHR, 8'h00, 0, 1, "shr");
    check_const("shr_86", 8'h86);

    // rotate / arithmetic
    apply(0, 1, MODE_LOAD, 8'h80, 0, 0, "load80");
    apply(0, 1, MODE_ROL, 8'h00, 0, 0, "rol");
    check_const("rol_01", 8'h01);
    apply(0, 1, MODE_ROR, 8'h00, 1, 1, "ror");
    check_const("ror_80", 8'h80);
    apply(0, 1, MODE_ASR, 8'h00, 0, 0, "asr_a");
    apply(0, 1, MODE_ASR, 8'h00, 0, 0, "asr_b");
    check_const("asr_e0", 8'hE0);
    apply(0, 1, MODE_LOAD, 8'h3C, 0, 0, "load3c");
    for (int i = 0; i < 8; i++) apply(0, 1, MODE_ROR, 8'h00, 1'(i), 1'(i + 1), "ror8");
    check_const("ror8_3c", 8'h3C);

    // enable low: no drift whatever mode says
    apply(0, 1, MODE_LOAD, 8'h5A, 0, 0, "load5a");
    for (int i = 0; i < 8; i++)
      apply(0, 0, 3'(i), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "en_low");
    check_const("hold_5a", 8'h5A);
    apply(0, 1, MODE_HOLD, 8'hFF, 1, 1, "hold");
    apply(0, 1, MODE_CLEAR, 8'hFF, 1, 1, "clear");
    check_const("clear_00", 8'h00);

    // reset mid-stream
    apply(0, 1, MODE_SHL, 8'h00, 1, 0, "mid_a");
    apply(0, 1, MODE_SHL, 8'h00, 1, 0, "mid_b");
    apply(0, 1, MODE_SHL, 8'h00, 1, 0, "mid_c");
    apply(1, 1, MODE_SHL, 8'h00, 1, 0, "mid_rst");
    check_const("mid_rst_a5", 8'hA5);
    apply(0, 1, MODE_SHR, 8'h00, 0, 0, "resume");

    // back-to-back random operations
    for (int i = 0; i < 24; i++)
      apply(0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "random");

    // chained serial-to-parallel
    word = 16'hBEEF;
    @(negedge clk);
    c_reset = 1'b0; c_en = 1'b1; c_mode = MODE_SHL;
    for (int i = 15; i >= 0; i--) begin
      c_sin = word[i];
      @(posedge clk);
      @(negedge clk);
    end
    c_en = 1'b0;
    checks++;
    assert ({q2, q1} === 16'hBEEF) else begin
      errors++;
      $error("FAIL chain got %h exp %h", {q2, q1}, 16'hBEEF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
